pipelined_barrel_shifter: RTL and testbench

//  Parametrised successor to the 4-bit rotate-right shifter. Shifts or rotates a

---
 rtl/pipelined_barrel_shifter_if.sv | 26 ++
 rtl/pipelined_barrel_shifter.sv | 93 +++++++++
 tb/tb_pipelined_barrel_shifter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter: an operand stream in and a result stream out.
// The shifter connects through the slave modport; its environment drives the master side.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit shifter/rotator with valid/ready handshakes on both sides.
// Rank 0 registers the operand; stage k then shifts by 2^k into rank k+1 (SHW-cycle latency).
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        MODE_ROR = 3'b000,
        MODE_ROL = 3'b001,
        MODE_LSR = 3'b010,
        MODE_LSL = 3'b011,
        MODE_ASR = 3'b100
    } mode_e;

    logic             en;
    logic             valid_d [0:SHW];
    logic             valid_q [0:SHW];
    logic [WIDTH-1:0] data_d  [0:SHW];
    logic [WIDTH-1:0] data_q  [0:SHW];
    logic [SHW-1:0]   amt_d   [0:SHW-1];
    logic [SHW-1:0]   amt_q   [0:SHW-1];
    logic [2:0]       mode_d  [0:SHW-1];
    logic [2:0]       mode_q  [0:SHW-1];

    // One log2 step; unlisted mode encodings fall through to rotate-right.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       mode,
                                                    input int               s);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
            MODE_LSR: r = d >> s;
            MODE_LSL: r = d << s;
            MODE_ASR: r = WIDTH'($signed(d) >>> s);
            default:  r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // The whole pipe advances together, so a full output rank stalls every rank, bubbles included.
    always_comb begin
        en         = !valid_q[SHW] || bus.out_ready;
        valid_d[0] = bus.in_valid && en;
        data_d[0]  = bus.in_data;
        amt_d[0]   = bus.in_amt;
        mode_d[0]  = bus.in_mode;
        for (int k = 0; k < SHW; k++) begin
            valid_d[k+1] = valid_q[k];
            data_d[k+1]  = amt_q[k][k] ? shift_step(data_q[k], mode_q[k], 1 << k) : data_q[k];
        end
        for (int k = 1; k < SHW; k++) begin
            amt_d[k]  = amt_q[k-1];
            mode_d[k] = mode_q[k-1];
        end
    end

    // NOTE: sequential state uses <= so every rank samples the pre-edge value of the one before it.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data ranks are cleared too, so out_data reads 0 straight after reset.
            for (int k = 0; k <= SHW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
            end
            for (int k = 0; k < SHW; k++) begin
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k <= SHW; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
            end
            for (int k = 0; k < SHW; k++) begin
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    // The last stage only consumes the top amount bit.
    logic unused_amt;
    assign unused_amt = ^amt_q[SHW-1][SHW-2:0];

    assign bus.in_ready  = en;
    assign bus.out_valid = valid_q[SHW];
    assign bus.out_data  = data_q[SHW];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed table, stream,
// stall, mid-stream reset and exhaustive sweep against a per-bit reference model.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach its summary line");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] amt;
        logic [2:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [14];

    logic [7:0] exp_q [$];
    logic       mon_en;
    logic       gap_chk;
    int         out_count;
    int         last_out_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: each output bit picked straight from the input word.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m);
        logic [7:0] r;
        int ai;
        ai = int'(a);
        r  = '0;
        for (int i = 0; i < 8; i++) begin
            case (m)
                3'd1:    r[i] = d[(i - ai + 8) % 8];
                3'd2:    r[i] = (i + ai < 8) ? d[i + ai] : 1'b0;
                3'd3:    r[i] = (i >= ai) ? d[i - ai] : 1'b0;
                3'd4:    r[i] = (i + ai < 8) ? d[i + ai] : d[7];
                default: r[i] = d[(i + ai) % 8];
            endcase
        end
        return r;
    endfunction

    // Scoreboard: samples at the falling edge, where handshake signals are settled for the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h with no word outstanding", bus.out_data);
                end else begin
                    check("stream_data", bus.out_data, exp_q.pop_front());
                end
                if (gap_chk && out_count > 0) check("stream_gap", cyc - last_out_cyc, 1);
                last_out_cyc = cyc;
                out_count++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_data, bus.in_amt, bus.in_mode));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m, input bit chk_rdy);
        bit acc;
        acc          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            if (c == 0 && chk_rdy) check("in_ready_high", bus.in_ready, 1);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        check("send_accepted", acc, 1);
    endtask

    // Single word into an empty pipe: out_valid must rise exactly 3 edges after acceptance.
    task automatic run_single(input string nm, input logic [7:0] d, input logic [2:0] a,
                              input logic [2:0] m, input logic [7:0] e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        @(negedge clk);
        check({nm, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) @(posedge clk);
            @(negedge clk);
            if (c < 3) begin
                check($sformatf("%s_early_valid_c%0d", nm, c), bus.out_valid, 0);
            end else begin
                check({nm, "_out_valid"}, bus.out_valid, 1);
                check({nm, "_out_data"}, bus.out_data, e);
            end
        end
    endtask

    task automatic wait_drain(input string nm, input int n);
        for (int c = 0; c < 40 && !(out_count == n && exp_q.size() == 0); c++) @(posedge clk);
        check({nm, "_count"}, out_count, n);
        check({nm, "_left"}, exp_q.size(), 0);
    endtask

    logic [7:0] stall_d [5];
    logic [2:0] stall_a [5];
    logic [2:0] stall_m [5];
    logic [7:0] exp_first;

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        out_count    = 0;
        last_out_cyc = 0;
        mon_en       = 1'b0;
        gap_chk      = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_amt   = '0;
        bus.in_mode  = '0;
        bus.out_ready = 1'b1;

        vecs[0]  = '{data: 8'h81, amt: 3'd1, mode: 3'd0, exp: 8'hC0};
        vecs[1]  = '{data: 8'h81, amt: 3'd1, mode: 3'd1, exp: 8'h03};
        vecs[2]  = '{data: 8'hA5, amt: 3'd0, mode: 3'd0, exp: 8'hA5};
        vecs[3]  = '{data: 8'h80, amt: 3'd7, mode: 3'd2, exp: 8'h01};
        vecs[4]  = '{data: 8'h0F, amt: 3'd4, mode: 3'd3, exp: 8'hF0};
        vecs[5]  = '{data: 8'h80, amt: 3'd3, mode: 3'd4, exp: 8'hF0};
        vecs[6]  = '{data: 8'h40, amt: 3'd3, mode: 3'd4, exp: 8'h08};
        vecs[7]  = '{data: 8'h81, amt: 3'd1, mode: 3'd7, exp: 8'hC0};
        vecs[8]  = '{data: 8'h12, amt: 3'd7, mode: 3'd1, exp: 8'h09};
        vecs[9]  = '{data: 8'hFF, amt: 3'd7, mode: 3'd3, exp: 8'h80};
        vecs[10] = '{data: 8'hFF, amt: 3'd0, mode: 3'd2, exp: 8'hFF};
        vecs[11] = '{data: 8'h7F, amt: 3'd7, mode: 3'd4, exp: 8'h00};
        vecs[12] = '{data: 8'h01, amt: 3'd7, mode: 3'd5, exp: 8'h02};
        vecs[13] = '{data: 8'h3C, amt: 3'd2, mode: 3'd6, exp: 8'h0F};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Directed table with exact-latency checks.
        for (int i = 0; i < 14; i++)
            run_single($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].mode, vecs[i].exp);

        // Back-to-back stream of 16 random words; results must come out on consecutive cycles.
        @(posedge clk);
        #1;
        mon_en    = 1'b1;
        gap_chk   = 1'b1;
        out_count = 0;
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
        bus.in_valid = 1'b0;
        wait_drain("stream", 16);
        gap_chk = 1'b0;

        // Consumer stalls while five words are offered; output must hold until released.
        for (int i = 0; i < 5; i++) begin
            stall_d[i] = 8'($urandom);
            stall_a[i] = 3'($urandom_range(1, 7));
            stall_m[i] = 3'($urandom_range(0, 4));
        end
        exp_first = model(stall_d[0], stall_a[0], stall_m[0]);
        @(posedge clk);
        #1;
        out_count     = 0;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(stall_d[i], stall_a[i], stall_m[i], 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (8) @(posedge clk);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_out_data", bus.out_data, exp_first);
                    check("stall_in_ready", bus.in_ready, 0);
                    @(posedge clk);
                end
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("stall", 5);

        // Reset with three words in flight: nothing of them may ever surface.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        send(8'h11, 3'd1, 3'd0, 1'b1);
        send(8'h22, 3'd2, 3'd1, 1'b1);
        send(8'h33, 3'd3, 3'd3, 1'b1);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_stale", bus.out_valid, 0);
        end
        run_single("post_rst", 8'hC3, 3'd2, 3'd1, 8'h0F);

        // Exhaustive sweep of all data, amounts and the five defined modes.
        @(posedge clk);
        #1;
        mon_en    = 1'b1;
        out_count = 0;
        for (int m = 0; m < 5; m++)
            for (int a = 0; a < 8; a++)
                for (int d = 0; d < 256; d++)
                    send(8'(d), 3'(a), 3'(m), 1'b0);
        bus.in_valid = 1'b0;
        wait_drain("exhaustive", 5 * 8 * 256);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
